// File: rtl/program_loader.sv
// UART-driven boot/debug front end: loads big-endian words into instruction memory
// and drives the pipeline's enable/reset for run, step and halt control.
module program_loader #(
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 256,
  parameter logic [7:0]  CMD_LOAD = 8'h4C,
  parameter logic [7:0]  CMD_RUN  = 8'h52,
  parameter logic [7:0]  CMD_STEP = 8'h53,
  parameter logic [7:0]  CMD_HALT = 8'h48,
  parameter logic [7:0]  ACK_BYTE = 8'h4B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              pipe_en,
  output logic              pipe_rst_n,
  output logic              busy,
  output logic              load_err
);

  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, ACK} state_t;

  localparam logic [16:0]     DEPTH_W = 17'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

  state_t          state;
  logic [7:0]      cnt_hi;
  logic [15:0]     count;
  logic [ADDR_W:0] word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     shift;
  logic            step_pulse;

  logic [15:0]     count_in;
  logic [ADDR_W:0] idx_inc;

  assign count_in = {cnt_hi, rx_data};
  assign idx_inc  = word_idx + IDX_ONE;

  // NOTE: every register here uses <= so all updates see the pre-edge values,
  // regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pipe_en    <= 1'b0;
      pipe_rst_n <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      load_err   <= 1'b0;
      cnt_hi     <= '0;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      step_pulse <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      imem_we  <= 1'b0;

      // A single step closes itself one cycle later unless a command below overrides it.
      if (step_pulse) begin
        pipe_en    <= 1'b0;
        step_pulse <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_LOAD: begin
                pipe_en    <= 1'b0;
                pipe_rst_n <= 1'b0;
                load_err   <= 1'b0;
                step_pulse <= 1'b0;
                busy       <= 1'b1;
                state      <= CNT_HI;
              end
              CMD_RUN: begin
                pipe_en    <= 1'b1;
                step_pulse <= 1'b0;
              end
              CMD_HALT: begin
                pipe_en    <= 1'b0;
                step_pulse <= 1'b0;
              end
              CMD_STEP: begin
                if (!pipe_en && pipe_rst_n) begin
                  pipe_en    <= 1'b1;
                  step_pulse <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        CNT_HI: begin
          if (rx_valid) begin
            cnt_hi <= rx_data;
            state  <= CNT_LO;
          end
        end

        CNT_LO: begin
          if (rx_valid) begin
            count <= count_in;
            if (count_in == 16'd0) begin
              state <= ACK;
            end else if ({1'b0, count_in} > DEPTH_W) begin
              load_err <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              word_idx <= '0;
              byte_idx <= '0;
              state    <= DATA;
            end
          end
        end

        DATA: begin
          if (rx_valid) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_W-1:0];
              imem_wdata <= {shift, rx_data};
              state      <= WRITE;
            end else begin
              shift <= {shift[15:0], rx_data};
            end
          end
        end

        WRITE: begin
          word_idx <= idx_inc;
          state    <= (16'(idx_inc) == count) ? ACK : DATA;
        end

        ACK: begin
          if (!tx_busy) begin
            tx_data    <= ACK_BYTE;
            tx_start   <= 1'b1;
            pipe_rst_n <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot/debug front end sitting directly upstream of the five-stage pipeline.
- Consumes a byte stream from the UART receiver and loads words into instruction memory, starting at word address 0.
- Drives the pipeline's enable and reset so the pipeline can be run, stepped or halted.
- After a load it sends a one-byte acknowledge through the UART transmitter.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, number of loadable words; must be ≤ 2^ADDR_W
CMD_LOAD, 8'h4C, load command byte ('L')
CMD_RUN, 8'h52, run command byte ('R')
CMD_STEP, 8'h53, single-step command byte ('S')
CMD_HALT, 8'h48, halt command byte ('H')
ACK_BYTE, 8'h4B, byte sent after a successful load ('K')

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data valid
tx_busy  in  1  transmitter busy
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit request
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  write data
pipe_en  out  1  pipeline clock enable (all pipeline registers and PC advance only when high)
pipe_rst_n  out  1  pipeline reset, active-low
busy  out  1  high in every state except IDLE
load_err  out  1  sticky: last load request had word count > DEPTH

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, pipe_en=0, pipe_rst_n=0, imem_we=0, imem_addr=0, imem_wdata=0, tx_start=0, tx_data=0, busy=0, load_err=0. Reset mid-load abandons the load; words already written stay in memory.
- Bytes are accepted only on cycles with rx_valid=1. Bytes arriving in WRITE or ACK are dropped.
- States: IDLE, CNT_HI, CNT_LO, DATA, WRITE, ACK.
- IDLE, on rx_data=CMD_LOAD:
  - set pipe_en=0 and pipe_rst_n=0; clear load_err; go to CNT_HI.
- IDLE, on CMD_RUN: pipe_en=1, held as a level.
- IDLE, on CMD_HALT: pipe_en=0.
- IDLE, on CMD_STEP:
  - If pipe_en=0 and pipe_rst_n=1: pipe_en=1 for exactly one cycle, then 0.
  - Otherwise ignored.
- IDLE, on any other byte: ignored, no state change.
- CNT_HI: latch count[15:8]; go to CNT_LO.
- CNT_LO: latch count[7:0], then:
  - count==0: go to ACK.
  - count>DEPTH: set load_err=1; go to IDLE with pipe_rst_n left at 0; no ack.
  - Otherwise: clear the word address and byte index; go to DATA.
- DATA: shift bytes in big-endian order (first byte lands in [31:24]). After the 4th byte, go to WRITE.
- WRITE: a single cycle.
  - imem_we=1 with imem_addr = current word index and imem_wdata = assembled word.
  - Then increment the word index.
  - If index+1==count, go to ACK; else go to DATA.
  - imem_we is high only in WRITE.
- ACK:
  - Wait while tx_busy=1.
  - On the first cycle with tx_busy=0: tx_data=ACK_BYTE, tx_start=1 for one cycle, pipe_rst_n=1, go to IDLE.
  - The pipeline leaves reset with pipe_en=0, so the host must send 'R' or 'S'.
- A simultaneous rx_valid and the ACK transmit resolve in favour of ACK; the byte is dropped.
- imem_addr and imem_wdata hold their last values outside WRITE.
- The word index is ADDR_W+1 bits wide, so count==DEPTH==2^ADDR_W terminates correctly; it never wraps.
- busy=1 in CNT_HI, CNT_LO, DATA, WRITE and ACK.

Test Plan:
1. Reset, then send 4C 00 02 12 34 56 78 9A BC DE F0, tx_busy=0.
   - Required: imem_we pulses twice, (addr0, 0x12345678) then (addr1, 0x9ABCDEF0).
   - Then tx_start for one cycle with tx_data=0x4B, pipe_rst_n rises, pipe_en stays 0.
2. After test 1, send 53.
   - Required: pipe_en high for exactly 1 cycle.
   - Then send 52: pipe_en stays high. Send 53: no change. Send 48: pipe_en=0.
3. Send 4C 01 01 (257 > DEPTH).
   - Required: load_err=1, no imem_we, no tx_start, pipe_rst_n=0, state IDLE.
   - A following valid load clears load_err.
4. Send 4C 00 00.
   - Required: no imem_we; ACK byte 0x4B sent; pipe_rst_n=1.
5. Hold tx_busy=1 through the end of a 1-word load, and send an extra byte while in ACK.
   - Required: tx_start stays 0 while busy and the extra byte is dropped.
   - tx_start fires one cycle after tx_busy falls.
6. Assert rst_n=0 after 2 of 4 data bytes, release, then send 52.
   - Required: all outputs at their reset values; byte 52 does set pipe_en=1, but pipe_rst_n stays 0 until the next completed load.
